// File: rtl/fifo_tx_pkg.sv
// Shared definitions for the FIFO serial transmitter.
//   - FSM state encoding (3-bit) and its enumerated type
//   - Line levels for the start bit, the stop bit and the idle line
package fifo_tx_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_POP   = S_POP,
    ST_LOAD  = S_LOAD,
    ST_START = S_START,
    ST_DATA  = S_DATA,
    ST_STOP  = S_STOP
  } tx_state_e;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// bit_timer: counts clock cycles within one serial bit.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   clear  in  force the count back to 0 on the next edge
//   tick   out high in the last cycle of a bit (count = CLKS_PER_BIT-1)
// The count wraps to 0 after each tick, so it never overflows.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  logic [CNT_WIDTH-1:0] count_reg;

  assign tick = (count_reg == CNT_WIDTH'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops words from a synchronous FIFO read port and sends
// each one as an asynchronous serial frame: start bit (0), FIFO_WIDTH data
// bits LSB first, stop bit (1).
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   tx_en      in  permits starting new frames (sampled only while idle)
//   empty      in  FIFO empty flag
//   rd_data    in  FIFO read data, valid the cycle after an accepted pop
//   rd_ena     out FIFO pop request (one cycle, in POP only)
//   tx         out serial line, idles high
//   busy       out high in every state except IDLE
//   frame_done out one-cycle pulse in the first IDLE cycle after a stop bit
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int FIFO_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic                  empty,
  input  logic [FIFO_WIDTH-1:0] rd_data,
  output logic                  rd_ena,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(FIFO_WIDTH) + 1;

  tx_state_e             state_reg;
  logic [FIFO_WIDTH-1:0] shift_reg;
  logic [FIFO_WIDTH-1:0] shift_next;
  logic [IDX_W-1:0]      bit_idx_reg;
  logic                  tx_reg;
  logic                  busy_reg;
  logic                  rd_ena_reg;
  logic                  frame_done_reg;
  logic                  timer_clear;
  logic                  tick;

  // The timer only runs while a bit is on the line; holding it clear
  // everywhere else guarantees a full-length start bit after LOAD.
  assign timer_clear = !(state_reg inside {ST_START, ST_DATA, ST_STOP});
  assign shift_next  = shift_reg >> 1;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(timer_clear),
    .tick (tick)
  );

  // Outputs are registered: each transition also loads the output values
  // that belong to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      bit_idx_reg    <= '0;
      tx_reg         <= IDLE_LEVEL;
      busy_reg       <= 1'b0;
      rd_ena_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      rd_ena_reg     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (tx_en && !empty) begin
            state_reg  <= ST_POP;
            rd_ena_reg <= 1'b1;
            busy_reg   <= 1'b1;
          end
        end
        ST_POP: begin
          // The pop is only honoured by the FIFO if it was non-empty.
          if (empty) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shift_reg   <= rd_data;
          bit_idx_reg <= '0;
          tx_reg      <= START_LEVEL;
          state_reg   <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            state_reg <= ST_DATA;
            tx_reg    <= shift_reg[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == IDX_W'(FIFO_WIDTH - 1)) begin
              state_reg <= ST_STOP;
              tx_reg    <= STOP_LEVEL;
            end else begin
              tx_reg <= shift_next[0];
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            state_reg      <= ST_IDLE;
            tx_reg         <= IDLE_LEVEL;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= IDLE_LEVEL;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_ena     = rd_ena_reg;
  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a queue-based FIFO model feeds the read port,
// every popped word is pushed into an expectation queue, and a monitor
// decodes the serial line and compares each frame against the frame rules.
module tb_fifo_serial_tx;

  localparam int W         = 4;
  localparam int CPB       = 4;
  localparam int FRAME_CYC = (W + 2) * CPB;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b1;
  logic         tx_en   = 1'b0;
  logic         empty   = 1'b1;
  logic [W-1:0] rd_data = '0;
  logic         rd_ena;
  logic         tx;
  logic         busy;
  logic         frame_done;

  fifo_serial_tx #(
    .FIFO_WIDTH  (W),
    .CLKS_PER_BIT(CPB),
    .CNT_WIDTH   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .empty     (empty),
    .rd_data   (rd_data),
    .rd_ena    (rd_ena),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dec_q[$];
  int           start_cyc[$];
  int           cyc         = 0;
  int           rd_count    = 0;
  int           fd_count    = 0;
  int           frames_seen = 0;

  task automatic check(input string name, input int act, input int req);
    n_asserts++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Line level required at cycle p of a frame carrying word.
  function automatic logic ref_level(input logic [W-1:0] word, input int p);
    int b;
    b = p / CPB;
    if (b == 0) return 1'b0;
    if (b <= W) return word[b-1];
    return 1'b1;
  endfunction

  // FIFO model: a pop accepted at an edge presents its word next cycle.
  initial begin : fifo_model
    logic [W-1:0] w;
    forever begin
      @(posedge clk);
      if (rst_n && rd_ena && !empty) begin
        w = fifo_q.pop_front();
        rd_data <= w;
        exp_q.push_back(w);
        empty <= (fifo_q.size() == 0);
      end
    end
  end

  // Monitor: one transaction line per completed frame.
  initial begin : monitor
    int           pos;
    int           err;
    logic [W-1:0] exp_w;
    logic [W-1:0] dec_w;
    pos = -1; err = 0; exp_w = '0; dec_w = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_ena) rd_count++;
      if (frame_done) fd_count++;
      if (!rst_n) begin
        pos = -1;
        exp_q.delete();
      end else if (pos < 0 && tx == 1'b0) begin
        start_cyc.push_back(cyc);
        check("frame_has_expected_word", int'(exp_q.size() > 0), 1);
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        pos = 0; err = 0; dec_w = '0;
      end
      if (rst_n && pos >= 0) begin
        if (pos < FRAME_CYC) begin
          if (tx !== ref_level(exp_w, pos)) err++;
          if (frame_done) err++;
          if ((pos % CPB) == CPB / 2 && pos / CPB >= 1 && pos / CPB <= W)
            dec_w[pos/CPB-1] = tx;
          pos++;
        end else begin
          $display("frame %0d: expected %h decoded %h bad_cycles %0d done %0b",
                   frames_seen, exp_w, dec_w, err, frame_done);
          check("frame_waveform_bad_cycles", err, 0);
          check("frame_done_after_stop", int'(frame_done), 1);
          dec_q.push_back(dec_w);
          frames_seen++;
          pos = -1;
        end
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    empty <= 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int b;
    b = budget;
    while (frames_seen < target && b > 0) begin
      tick_n(1);
      b--;
    end
    check(name, int'(frames_seen >= target), 1);
  endtask

  function automatic int get_start(input int idx);
    return (start_cyc.size() > idx) ? start_cyc[idx] : -1000;
  endfunction

  function automatic int get_dec(input int idx);
    return (dec_q.size() > idx) ? int'(dec_q[idx]) : -1;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base_rd, base_fd, base_fr, base_st, base_dec, t0, s1, s2, n_words, bad;
    logic any_rd, any_busy, any_fd, any_low;
    logic [W-1:0] rnd_q[$];
    logic [W-1:0] w;

    // Asynchronous reset takes effect without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_rd_ena", rd_ena, 0);
    check("reset_frame_done", frame_done, 0);
    tick_n(3);
    rst_n = 1'b1;
    tick_n(2);

    // Single word 4'hA.
    base_rd = rd_count; base_fd = fd_count; base_fr = frames_seen;
    base_st = start_cyc.size(); base_dec = dec_q.size();
    push(4'hA);
    tick_n(1);
    tx_en = 1'b1;
    t0 = cyc;
    wait_frames(base_fr + 1, 100, "single_frame_timeout");
    tick_n(5);
    check("single_rd_pulses", rd_count - base_rd, 1);
    check("single_frame_done_pulses", fd_count - base_fd, 1);
    check("single_start_latency", get_start(base_st) - t0, 3);
    check("single_word", get_dec(base_dec), 'hA);

    // Back-to-back 4'h1, 4'hF.
    base_rd = rd_count; base_st = start_cyc.size(); base_dec = dec_q.size();
    base_fr = frames_seen;
    push(4'h1);
    push(4'hF);
    wait_frames(base_fr + 2, 150, "b2b_frames_timeout");
    tick_n(5);
    s1 = get_start(base_st);
    s2 = get_start(base_st + 1);
    check("b2b_idle_gap", s2 - (s1 + FRAME_CYC), 3);
    check("b2b_rd_pulses", rd_count - base_rd, 2);
    check("b2b_word0", get_dec(base_dec), 'h1);
    check("b2b_word1", get_dec(base_dec + 1), 'hF);

    // Empty FIFO with tx_en held high.
    any_rd = 1'b0; any_busy = 1'b0; any_fd = 1'b0; any_low = 1'b0;
    repeat (50) begin
      tick_n(1);
      any_rd   |= rd_ena;
      any_busy |= busy;
      any_fd   |= frame_done;
      any_low  |= !tx;
    end
    check("empty_rd_ena", any_rd, 0);
    check("empty_busy", any_busy, 0);
    check("empty_frame_done", any_fd, 0);
    check("empty_tx_low", any_low, 0);

    // tx_en dropped during DATA of 4'h5 while 4'h6 waits.
    tx_en = 1'b0;
    base_rd = rd_count; base_fr = frames_seen; base_dec = dec_q.size();
    push(4'h5);
    push(4'h6);
    tick_n(1);
    tx_en = 1'b1;
    tick_n(9);
    check("drop_busy_mid_data", busy, 1);
    tx_en = 1'b0;
    wait_frames(base_fr + 1, 100, "drop_frame_timeout");
    tick_n(30);
    check("drop_rd_pulses", rd_count - base_rd, 1);
    check("drop_fifo_left", fifo_q.size(), 1);
    check("drop_frames", frames_seen - base_fr, 1);
    check("drop_word", get_dec(base_dec), 'h5);
    fifo_q.delete();
    empty <= 1'b1;
    tick_n(1);

    // Asynchronous reset in the middle of a data bit.
    push(4'h7);
    tick_n(1);
    tx_en = 1'b1;
    tick_n(9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx_high", tx, 1);
    check("arst_busy_low", busy, 0);
    check("arst_rd_ena_low", rd_ena, 0);
    tx_en = 1'b0;
    tick_n(3);
    base_rd = rd_count; base_fr = frames_seen; base_dec = dec_q.size();
    push(4'h3);
    rst_n = 1'b1;
    tick_n(1);
    tx_en = 1'b1;
    wait_frames(base_fr + 1, 100, "arst_frame_timeout");
    tick_n(5);
    check("arst_next_word", get_dec(base_dec), 'h3);
    check("arst_rd_pulses", rd_count - base_rd, 1);
    check("arst_frames", frames_seen - base_fr, 1);

    // Randomised traffic with tx_en toggling.
    base_fr = frames_seen; base_dec = dec_q.size();
    n_words = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && n_words < 30) begin
        w = W'($urandom);
        rnd_q.push_back(w);
        push(w);
        n_words++;
      end
      tx_en = ($urandom_range(0, 9) != 0);
      tick_n(1);
    end
    tx_en = 1'b1;
    wait_frames(base_fr + n_words, 2000, "rand_drain_timeout");
    tick_n(10);
    check("rand_frames", frames_seen - base_fr, n_words);
    bad = 0;
    for (int k = 0; k < n_words; k++) begin
      if (get_dec(base_dec + k) != int'(rnd_q[k])) bad++;
    end
    check("rand_words_in_order", bad, 0);
    check("rand_exp_queue_drained", exp_q.size(), 0);
    check("rand_fifo_drained", fifo_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Read-side consumer for the sync FIFO: pops `FIFO_WIDTH`-bit words through the FIFO read port and transmits each word as an asynchronous serial frame on one line. The frame is a start bit (0), `FIFO_WIDTH` data bits LSB first, then a stop bit (1). The block sits between the FIFO's read port (`rd_ena`/`rd_data`/`empty`) and the pad.

## Interface
- `FIFO_WIDTH`, 4: data bits per word/frame.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; must be ≥ 2.
- `CNT_WIDTH`, 8: bit-timer width; `CLKS_PER_BIT` ≤ 2^`CNT_WIDTH`.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_en`  in  1  permits starting new frames.
- `empty`  in  1  FIFO empty flag.
- `rd_data`  in  FIFO_WIDTH  FIFO read data; valid the cycle after a cycle with `rd_ena`=1 and `empty`=0.
- `rd_ena`  out  1  FIFO pop request.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse after each completed stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: `tx`=1. If `tx_en`=1 and `empty`=0, go to POP. Otherwise stay in IDLE.
- POP: `rd_ena`=1 for exactly this cycle (decoded from state). If `empty`=1 in this cycle, return to IDLE with no frame. Otherwise go to LOAD.
- LOAD: capture `rd_data` into the shift register, clear the bit timer and bit index, and go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: `tx`=shift[0]. Each `CLKS_PER_BIT` cycles, shift right by one and increment the bit index. After bit `FIFO_WIDTH`-1 completes, go to STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE and assert `frame_done` for one cycle.
- Bit timer counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary. The bit index is `$clog2(FIFO_WIDTH)+1` bits wide. Neither counter overflows.
- `tx_en` is sampled only in IDLE. Deasserting it mid-frame does not truncate the frame; no further pops occur.
- The FIFO is never popped while a frame is in flight. There is at most one outstanding pop.

## Timing
- Reset (async assert): `tx`=1, `busy`=0, `rd_ena`=0, `frame_done`=0, state IDLE, counters 0. This takes effect immediately, without waiting for a clock.
- Reset mid-frame: the line returns high at once. The popped word is dropped and is not re-read.
- Latency, measured from the first edge seeing `tx_en`=1 and `empty`=0 in IDLE:
  - POP occupies the next cycle.
  - LOAD occupies the cycle after POP.
  - The start bit begins on the line 3 cycles after that edge.
- Frame duration: (`FIFO_WIDTH`+2)·`CLKS_PER_BIT` cycles, i.e. 24 cycles at the defaults.
- Back-to-back frames: IDLE+POP+LOAD insert 3 idle-high cycles between one stop bit and the next start bit.
- `frame_done` is registered and fires in the first IDLE cycle after STOP.
- `busy` rises in POP and falls in that same IDLE cycle.

## Structure
- Shared package `fifo_tx_pkg` holds:
  - state encoding localparams (3-bit: IDLE=0, POP=1, LOAD=2, START=3, DATA=4, STOP=5);
  - frame constants (start level 0, stop level 1, idle level 1).
- Sub-module `bit_timer`:
  - `CNT_WIDTH` counter with `clear` input;
  - `tick` output high when count = `CLKS_PER_BIT`-1;
  - clocked by `clk`, reset by `rst_n`.
- Top level contains the FSM, shift register and bit index.
- Integration: the top level of the design connects the FIFO read port directly to this block.

## Test plan
All scenarios use the defaults (`FIFO_WIDTH`=4, `CLKS_PER_BIT`=4).

- Single word: push 4'hA, set `tx_en`=1.
  - Exactly one `rd_ena` pulse.
  - `tx` sequence: 0×4, 0×4, 1×4, 0×4, 1×4, 1×4.
  - `frame_done` pulses once, 24 cycles after the start bit begins.
- Back-to-back: push 4'h1 then 4'hF.
  - Two frames with data bits 1000 and 1111 (LSB first).
  - Exactly 3 high cycles between the first stop bit's end and the second start bit.
  - 2 `rd_ena` pulses in total.
- Empty FIFO: `tx_en`=1, `empty`=1 for 50 cycles → `rd_ena`, `busy` and `frame_done` stay 0; `tx` stays 1.
- `tx_en` drop: deassert `tx_en` during DATA of word 4'h5 with 4'h6 still queued.
  - The 4'h5 frame completes.
  - No further `rd_ena`; 4'h6 stays in the FIFO.
- Async reset: assert `rst_n`=0 mid-DATA between clock edges.
  - `tx`=1 and `busy`=0 before the next edge.
  - After release with 4'h3 queued, the next frame carries 4'h3.
